// File: rtl/wb_ksa_responder.sv
// -----------------------------------------------------------------------------
// wb_ksa_responder
//   Wishbone responder that lets the management SoC drive the user-area adder
//   over the bus. The SoC writes two operands and a start bit, polls STATUS or
//   takes irq[0], then reads RESULT = {cout, sum}.
//
// Ports
//   wb_clk_i   in   1   single clock for all logic
//   wb_rst_i   in   1   asynchronous, active-high reset
//   wbs_stb_i  in   1   WB strobe
//   wbs_cyc_i  in   1   WB cycle
//   wbs_we_i   in   1   WB write enable
//   wbs_sel_i  in   4   WB byte selects
//   wbs_dat_i  in   32  WB write data
//   wbs_adr_i  in   32  WB byte address (window decoded on [31:8])
//   wbs_ack_o  out  1   WB acknowledge (registered, one-cycle pulse)
//   wbs_dat_o  out  32  WB read data (registered)
//   irq        out  3   irq[0] = done & irq_en; irq[2:1] tied 0
//
// Register map (offset = wbs_adr_i[7:0])
//   0x00 OPA    RW [WIDTH-1:0]
//   0x04 OPB    RW [WIDTH-1:0]
//   0x08 CTRL   bit0 start (write-only, self-clearing), bit1 irq_en (RW)
//   0x0C STATUS bit0 busy, bit1 done (write 1 clears), bit2 cout
//   0x10 RESULT [WIDTH:0] = {cout, sum}
// -----------------------------------------------------------------------------
module wb_ksa_responder #(
    parameter int unsigned WIDTH    = 16,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned LATENCY  = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] OFF_OPA    = 8'h00;
    localparam logic [7:0] OFF_OPB    = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_RESULT = 8'h10;
    localparam logic [3:0] CNT_INIT   = 4'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;     // operands captured at start
    logic [WIDTH:0]   result_q, result_d;
    logic             irq_en_q, irq_en_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;

    logic        valid, access, wr, start, clear_done, busy, done;
    logic [7:0]  offset;
    logic [31:0] rdata;
    logic        unused_ok;

    // Per-byte write merge; bit i of a register belongs to byte lane i/8.
    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] new_v,
        input logic [3:0]       sel
    );
        logic [WIDTH-1:0] r;
        r = old_v;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel[i / 8]) r[i] = new_v[i];
        end
        return r;
    endfunction

    assign offset = wbs_adr_i[7:0];
    assign valid  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    // Accept only when ack is low, so every access gets exactly one ack pulse.
    assign access = valid & ~ack_q;
    assign wr     = access & wbs_we_i;

    assign start      = wr && (offset == OFF_CTRL)   && wbs_sel_i[0] && wbs_dat_i[0];
    assign clear_done = wr && (offset == OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[1];

    assign busy = (state_q == S_BUSY);
    assign done = (state_q == S_DONE);

    // Upper data bits and byte lanes beyond the registers are not stored.
    assign unused_ok = ^{wbs_dat_i, wbs_sel_i};

    // Read mux: unmapped offsets and unused upper bits read as zero.
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_OPA:    rdata[WIDTH-1:0] = opa_q;
            OFF_OPB:    rdata[WIDTH-1:0] = opb_q;
            OFF_CTRL:   rdata[1]         = irq_en_q;
            // cout is reported alongside done so that clearing done reads back 0.
            OFF_STATUS: rdata[2:0]       = {result_q[WIDTH] & done, done, busy};
            OFF_RESULT: rdata[WIDTH:0]   = result_q;
            default:    rdata            = '0;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal takes its held value first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        irq_en_d = irq_en_q;
        ack_d    = access;
        dat_d    = dat_q;

        if (access && !wbs_we_i) dat_d = rdata;

        if (wr) begin
            case (offset)
                OFF_OPA:  opa_d = byte_merge(opa_q, wbs_dat_i[WIDTH-1:0], wbs_sel_i);
                OFF_OPB:  opb_d = byte_merge(opb_q, wbs_dat_i[WIDTH-1:0], wbs_sel_i);
                OFF_CTRL: if (wbs_sel_i[0]) irq_en_d = wbs_dat_i[1];
                default:  ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = opa_q;
                    b_d     = opb_q;
                    cnt_d   = CNT_INIT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // start is deliberately ignored here; operands are already captured.
                if (cnt_q == 4'd0) begin
                    result_d = {1'b0, a_q} + {1'b0, b_q};
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                // start has priority over a done-clear.
                if (start) begin
                    a_d     = opa_q;
                    b_d     = opb_q;
                    cnt_d   = CNT_INIT;
                    state_d = S_BUSY;
                end else if (clear_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            irq_en_q <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            irq_en_q <= irq_en_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = {2'b00, done & irq_en_q};

endmodule
